// File: rtl/pci_blue_response_arbiter.sv
// pci_blue_response_arbiter
//
// This block shares the Host Interface Response FIFO write port between two producers:
//   - PCI Target path: multi-entry references. tgt_resp_last marks the final entry.
//   - PCI Master path: single-entry status reports.
// Each producer writes into its own HOLD_DEPTH-entry circular holding buffer. A burst-atomic
// arbiter drains the two buffers into the FIFO. Once a Target reference has been granted, it
// is never interleaved with Master entries. Flow control comes from the FIFO's asynchronous
// room flag, which is passed through a two-flop synchronizer.
//
// Optional feature: when `PCI_BLUE_RESP_ROUND_ROBIN_EN is defined, ties in IDLE alternate
// between the producers, and Target wins the first tie. Otherwise Master wins every tie.
//
// Ports:
//   pci_clk, pci_reset_comb        clock; asynchronous active-high reset
//   tgt_resp_*                     Target entry in (type/cbe/data/last/load)
//   tgt_resp_room                  out: Target buffer not full
//   tgt_resp_error                 out: sticky Target overflow or FIFO error
//   pci_master_to_target_request_* Master entry in, room out, sticky error out
//   pci_iface_response_*           registered FIFO write port out; async room and error in
module pci_blue_response_arbiter #(
  parameter int unsigned HOLD_DEPTH = 4
) (
  input  logic        pci_clk,
  input  logic        pci_reset_comb,
  input  logic [2:0]  tgt_resp_type,
  input  logic [3:0]  tgt_resp_cbe,
  input  logic [31:0] tgt_resp_data,
  input  logic        tgt_resp_last,
  input  logic        tgt_resp_load,
  output logic        tgt_resp_room,
  output logic        tgt_resp_error,
  input  logic [2:0]  pci_master_to_target_request_type,
  input  logic [3:0]  pci_master_to_target_request_cbe,
  input  logic [31:0] pci_master_to_target_request_data,
  input  logic        pci_master_to_target_request_data_load,
  output logic        pci_master_to_target_request_room_available_meta,
  output logic        pci_master_to_target_request_error,
  output logic [3:0]  pci_iface_response_type,
  output logic [3:0]  pci_iface_response_cbe,
  output logic [31:0] pci_iface_response_data,
  output logic        pci_iface_response_data_load,
  input  logic        pci_iface_response_room_available_meta,
  input  logic        pci_iface_response_error
);

  localparam int unsigned PtrW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(HOLD_DEPTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  typedef enum logic [1:0] {StIdle, StGrantTgt, StGrantMst} arb_state_e;

  // ---------------------------------------------------------------------------
  // Target holding buffer: entry = {last, type[2:0], cbe[3:0], data[31:0]}
  // ---------------------------------------------------------------------------
  logic [39:0]     tgt_mem [HOLD_DEPTH];
  logic [PtrW-1:0] tgt_wptr_q, tgt_wptr_d;
  logic [PtrW-1:0] tgt_rptr_q, tgt_rptr_d;
  logic [CntW-1:0] tgt_cnt_q, tgt_cnt_d;
  logic            tgt_room, tgt_avail, tgt_push, tgt_pop;
  logic [39:0]     tgt_head;

  assign tgt_room  = (tgt_cnt_q != CntFull);
  assign tgt_avail = (tgt_cnt_q != '0);
  // A load without room is dropped even if a pop frees a slot in the same cycle.
  assign tgt_push  = tgt_resp_load & tgt_room;
  assign tgt_head  = tgt_mem[tgt_rptr_q];

  always_comb begin
    tgt_wptr_d = tgt_wptr_q;
    tgt_rptr_d = tgt_rptr_q;
    tgt_cnt_d  = tgt_cnt_q;
    if (tgt_push) tgt_wptr_d = tgt_wptr_q + PtrOne;
    if (tgt_pop)  tgt_rptr_d = tgt_rptr_q + PtrOne;
    if (tgt_push && !tgt_pop) begin
      tgt_cnt_d = tgt_cnt_q + CntOne;
    end else if (!tgt_push && tgt_pop) begin
      tgt_cnt_d = tgt_cnt_q - CntOne;
    end
  end

  always_ff @(posedge pci_clk or posedge pci_reset_comb) begin
    if (pci_reset_comb) begin
      tgt_wptr_q <= '0;
      tgt_rptr_q <= '0;
      tgt_cnt_q  <= '0;
    end else begin
      tgt_wptr_q <= tgt_wptr_d;
      tgt_rptr_q <= tgt_rptr_d;
      tgt_cnt_q  <= tgt_cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after its count slot is valid.
  always_ff @(posedge pci_clk) begin
    if (tgt_push) begin
      tgt_mem[tgt_wptr_q] <= {tgt_resp_last, tgt_resp_type, tgt_resp_cbe, tgt_resp_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Master holding buffer: entry = {type[2:0], cbe[3:0], data[31:0]}
  // ---------------------------------------------------------------------------
  logic [38:0]     mst_mem [HOLD_DEPTH];
  logic [PtrW-1:0] mst_wptr_q, mst_wptr_d;
  logic [PtrW-1:0] mst_rptr_q, mst_rptr_d;
  logic [CntW-1:0] mst_cnt_q, mst_cnt_d;
  logic            mst_room, mst_avail, mst_push, mst_pop;
  logic [38:0]     mst_head;

  assign mst_room  = (mst_cnt_q != CntFull);
  assign mst_avail = (mst_cnt_q != '0);
  assign mst_push  = pci_master_to_target_request_data_load & mst_room;
  assign mst_head  = mst_mem[mst_rptr_q];

  always_comb begin
    mst_wptr_d = mst_wptr_q;
    mst_rptr_d = mst_rptr_q;
    mst_cnt_d  = mst_cnt_q;
    if (mst_push) mst_wptr_d = mst_wptr_q + PtrOne;
    if (mst_pop)  mst_rptr_d = mst_rptr_q + PtrOne;
    if (mst_push && !mst_pop) begin
      mst_cnt_d = mst_cnt_q + CntOne;
    end else if (!mst_push && mst_pop) begin
      mst_cnt_d = mst_cnt_q - CntOne;
    end
  end

  always_ff @(posedge pci_clk or posedge pci_reset_comb) begin
    if (pci_reset_comb) begin
      mst_wptr_q <= '0;
      mst_rptr_q <= '0;
      mst_cnt_q  <= '0;
    end else begin
      mst_wptr_q <= mst_wptr_d;
      mst_rptr_q <= mst_rptr_d;
      mst_cnt_q  <= mst_cnt_d;
    end
  end

  always_ff @(posedge pci_clk) begin
    if (mst_push) begin
      mst_mem[mst_wptr_q] <= {pci_master_to_target_request_type,
                              pci_master_to_target_request_cbe,
                              pci_master_to_target_request_data};
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO room synchronizer. The FIFO reserves enough slack for the two sync
  // stages, the output register and one pop already in flight.
  // ---------------------------------------------------------------------------
  logic room_meta_q, room_sync_q;

  always_ff @(posedge pci_clk or posedge pci_reset_comb) begin
    if (pci_reset_comb) begin
      room_meta_q <= 1'b0;
      room_sync_q <= 1'b0;
    end else begin
      room_meta_q <= pci_iface_response_room_available_meta;
      room_sync_q <= room_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------------
  arb_state_e state_q, state_d;

`ifdef PCI_BLUE_RESP_ROUND_ROBIN_EN
  // Records who was granted last. It resets to Master, so Target wins the first tie.
  logic last_mst_q, last_mst_d;

  always_ff @(posedge pci_clk or posedge pci_reset_comb) begin
    if (pci_reset_comb) begin
      last_mst_q <= 1'b1;
    end else begin
      last_mst_q <= last_mst_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    tgt_pop = 1'b0;
    mst_pop = 1'b0;
`ifdef PCI_BLUE_RESP_ROUND_ROBIN_EN
    last_mst_d = last_mst_q;
`endif
    unique case (state_q)
      StIdle: begin
        // The grant is registered here; nothing pops in the IDLE cycle.
        if (tgt_avail && mst_avail) begin
`ifdef PCI_BLUE_RESP_ROUND_ROBIN_EN
          if (last_mst_q) begin
            state_d    = StGrantTgt;
            last_mst_d = 1'b0;
          end else begin
            state_d    = StGrantMst;
            last_mst_d = 1'b1;
          end
`else
          state_d = StGrantMst;
`endif
        end else if (tgt_avail) begin
          state_d = StGrantTgt;
`ifdef PCI_BLUE_RESP_ROUND_ROBIN_EN
          last_mst_d = 1'b0;
`endif
        end else if (mst_avail) begin
          state_d = StGrantMst;
`ifdef PCI_BLUE_RESP_ROUND_ROBIN_EN
          last_mst_d = 1'b1;
`endif
        end
      end
      StGrantTgt: begin
        // If the buffer empties mid-reference, keep the grant and wait for the rest of it.
        if (room_sync_q && tgt_avail) begin
          tgt_pop = 1'b1;
          if (tgt_head[39]) state_d = StIdle;
        end
      end
      StGrantMst: begin
        if (room_sync_q && mst_avail) begin
          mst_pop = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pci_clk or posedge pci_reset_comb) begin
    if (pci_reset_comb) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered FIFO write port. Bit 3 of the type distinguishes Master from Target.
  // ---------------------------------------------------------------------------
  logic        load_q;
  logic [3:0]  type_q;
  logic [3:0]  cbe_q;
  logic [31:0] data_q;

  always_ff @(posedge pci_clk or posedge pci_reset_comb) begin
    if (pci_reset_comb) begin
      load_q <= 1'b0;
      type_q <= '0;
      cbe_q  <= '0;
      data_q <= '0;
    end else begin
      load_q <= tgt_pop | mst_pop;
      if (tgt_pop) begin
        type_q <= {1'b0, tgt_head[38:36]};
        cbe_q  <= tgt_head[35:32];
        data_q <= tgt_head[31:0];
      end else if (mst_pop) begin
        type_q <= {1'b1, mst_head[38:36]};
        cbe_q  <= mst_head[35:32];
        data_q <= mst_head[31:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags. They are cleared only by reset.
  // ---------------------------------------------------------------------------
  logic tgt_err_q, mst_err_q;

  always_ff @(posedge pci_clk or posedge pci_reset_comb) begin
    if (pci_reset_comb) begin
      tgt_err_q <= 1'b0;
      mst_err_q <= 1'b0;
    end else begin
      tgt_err_q <= tgt_err_q | (tgt_resp_load & ~tgt_room) | pci_iface_response_error;
      mst_err_q <= mst_err_q | (pci_master_to_target_request_data_load & ~mst_room)
                 | pci_iface_response_error;
    end
  end

  assign tgt_resp_room                                    = tgt_room;
  assign tgt_resp_error                                   = tgt_err_q;
  assign pci_master_to_target_request_room_available_meta = mst_room;
  assign pci_master_to_target_request_error               = mst_err_q;
  assign pci_iface_response_type                          = type_q;
  assign pci_iface_response_cbe                           = cbe_q;
  assign pci_iface_response_data                          = data_q;
  assign pci_iface_response_data_load                     = load_q;

endmodule

// File: tb/tb_pci_blue_response_arbiter.sv
// Self-checking bench for pci_blue_response_arbiter (HOLD_DEPTH = 4).
module tb_pci_blue_response_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  t_type = '0;
  logic [3:0]  t_cbe = '0;
  logic [31:0] t_data = '0;
  logic        t_last = 1'b0;
  logic        t_load = 1'b0;
  logic        t_room, t_err;
  logic [2:0]  m_type = '0;
  logic [3:0]  m_cbe = '0;
  logic [31:0] m_data = '0;
  logic        m_load = 1'b0;
  logic        m_room, m_err;
  logic [3:0]  o_type;
  logic [3:0]  o_cbe;
  logic [31:0] o_data;
  logic        o_load;
  logic        meta = 1'b1;
  logic        f_err = 1'b0;

  pci_blue_response_arbiter #(.HOLD_DEPTH(4)) dut (
    .pci_clk                                          (clk),
    .pci_reset_comb                                   (rst),
    .tgt_resp_type                                    (t_type),
    .tgt_resp_cbe                                     (t_cbe),
    .tgt_resp_data                                    (t_data),
    .tgt_resp_last                                    (t_last),
    .tgt_resp_load                                    (t_load),
    .tgt_resp_room                                    (t_room),
    .tgt_resp_error                                   (t_err),
    .pci_master_to_target_request_type                (m_type),
    .pci_master_to_target_request_cbe                 (m_cbe),
    .pci_master_to_target_request_data                (m_data),
    .pci_master_to_target_request_data_load           (m_load),
    .pci_master_to_target_request_room_available_meta (m_room),
    .pci_master_to_target_request_error               (m_err),
    .pci_iface_response_type                          (o_type),
    .pci_iface_response_cbe                           (o_cbe),
    .pci_iface_response_data                          (o_data),
    .pci_iface_response_data_load                     (o_load),
    .pci_iface_response_room_available_meta           (meta),
    .pci_iface_response_error                         (f_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Every FIFO write, captured on the falling edge as {type, cbe, data}.
  logic [39:0] obs[$];
  always @(negedge clk) if (o_load) obs.push_back({o_type, o_cbe, o_data});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load"}, o_load, 0);
    check({tag, "_type"}, o_type, 0);
    check({tag, "_cbe"}, o_cbe, 0);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_terr"}, t_err, 0);
    check({tag, "_merr"}, m_err, 0);
    check({tag, "_troom"}, t_room, 1);
    check({tag, "_mroom"}, m_room, 1);
  endtask

  // Reset, then leave room_sync settled high.
  task automatic do_reset();
    t_load = 0; m_load = 0; f_err = 0; meta = 1;
    rst = 1;
    step();
    step();
    rst = 0;
    step(); step(); step();
  endtask

  typedef struct packed {
    logic        t_ld;
    logic [31:0] t_dat;
    logic        t_lst;
    logic        m_ld;
    logic [31:0] m_dat;
    logic        e_ld;
    logic [3:0]  e_type;
    logic [3:0]  e_cbe;
    logic [31:0] e_data;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] got[$];
  logic [39:0] tq[$];
  logic [38:0] mq[$];
  logic [39:0] e;
  logic [39:0] te;
  logic [38:0] me;
  logic        exp_m [4];
  int          drop_c, rise_c, ti, mi, tgt_left, total, bound;
  logic        in_tgt;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // ---------------- reset values ----------------
    step();
    check_reset_outputs("reset");
    do_reset();

    // ---------------- table: Target reference, then Master entry ----------------
    // Target entries use type 3'b010, cbe 4'hA. The Master entry uses type 3'b101, cbe 4'h5.
    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    1'b0, 4'h0, 4'h0, 32'h0};
    vecs[1] = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h0,    1'b0, 4'h0, 4'h0, 32'h0};
    vecs[2] = '{1'b1, 32'h108, 1'b1, 1'b0, 32'h0,    1'b1, 4'h2, 4'hA, 32'h100};
    vecs[3] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'hDEAD, 1'b1, 4'h2, 4'hA, 32'h104};
    vecs[4] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    1'b1, 4'h2, 4'hA, 32'h108};
    vecs[5] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    1'b0, 4'h2, 4'hA, 32'h108};
    vecs[6] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    1'b1, 4'hD, 4'h5, 32'hDEAD};
    vecs[7] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    1'b0, 4'hD, 4'h5, 32'hDEAD};
    t_type = 3'b010; t_cbe = 4'hA; m_type = 3'b101; m_cbe = 4'h5;
    for (int i = 0; i < 8; i++) begin
      t_load = vecs[i].t_ld; t_data = vecs[i].t_dat; t_last = vecs[i].t_lst;
      m_load = vecs[i].m_ld; m_data = vecs[i].m_dat;
      step();
      check($sformatf("vec%0d_load", i), o_load, vecs[i].e_ld);
      check($sformatf("vec%0d_type", i), o_type, vecs[i].e_type);
      check($sformatf("vec%0d_cbe", i), o_cbe, vecs[i].e_cbe);
      check($sformatf("vec%0d_data", i), o_data, vecs[i].e_data);
    end
    t_load = 0; m_load = 0;

    // ---------------- FIFO back-pressure on a 6-entry Target burst ----------------
    got.delete();
    drop_c = -1; rise_c = -1; ti = 0;
    t_type = 3'b011; t_cbe = 4'hF;
    for (int c = 0; c < 80 && got.size() < 6; c++) begin
      t_load = (ti < 6) && t_room;
      t_data = 32'h200 + 32'(4 * ti);
      t_last = (ti == 5);
      if (t_load) ti++;
      step();
      if (o_load) got.push_back(o_data);
      if (drop_c >= 0 && rise_c < 0 && c >= drop_c + 3) check("bp_stop", o_load, 0);
      if (rise_c >= 0 && (c == rise_c + 1 || c == rise_c + 2)) check("bp_wait", o_load, 0);
      if (rise_c >= 0 && c == rise_c + 3) check("bp_resume", o_load, 1);
      if (drop_c < 0 && got.size() == 2) begin
        meta = 0; drop_c = c;
      end else if (drop_c >= 0 && rise_c < 0 && c == drop_c + 6) begin
        meta = 1; rise_c = c;
      end
    end
    t_load = 0; t_last = 0;
    check("bp_count", got.size(), 6);
    for (int i = 0; i < got.size() && i < 6; i++)
      check($sformatf("bp_data%0d", i), got[i], 32'h200 + 32'(4 * i));
    step(); step();

    // ---------------- Target overflow ----------------
    do_reset();
    obs.delete();
    meta = 0;
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      t_load = 1; t_data = 32'h300 + 32'(4 * i); t_last = 0;
      step();
      check($sformatf("ovf_room%0d", i), t_room, (i < 3));
      check($sformatf("ovf_err%0d", i), t_err, (i == 4));
    end
    t_load = 0;
    step();
    check("ovf_err_sticky", t_err, 1);
    meta = 1;
    bound = 0;
    while (!t_room && bound < 20) begin step(); bound++; end
    check("ovf_room_back", t_room, 1);
    t_load = 1; t_data = 32'h314; t_last = 1;
    step();
    t_load = 0; t_last = 0;
    for (int i = 0; i < 10; i++) step();
    check("ovf_count", obs.size(), 5);
    for (int i = 0; i < obs.size() && i < 5; i++)
      check($sformatf("ovf_data%0d", i), obs[i][31:0], (i < 4) ? 32'h300 + 32'(4 * i) : 32'h314);
    check("ovf_terr_hold", t_err, 1);
    check("ovf_merr", m_err, 0);
    f_err = 1;
    step();
    f_err = 0;
    step();
    check("ferr_merr", m_err, 1);
    check("ferr_terr", t_err, 1);

    // ---------------- tie arbitration ----------------
    do_reset();
    check("post_reset_terr", t_err, 0);
    check("post_reset_merr", m_err, 0);
    obs.delete();
`ifdef PCI_BLUE_RESP_ROUND_ROBIN_EN
    exp_m[0] = 0; exp_m[1] = 1; exp_m[2] = 0; exp_m[3] = 1;
`else
    exp_m[0] = 1; exp_m[1] = 1; exp_m[2] = 0; exp_m[3] = 0;
`endif
    t_type = 3'b001; t_cbe = 4'h3; m_type = 3'b110; m_cbe = 4'hC;
    for (int i = 0; i < 2; i++) begin
      t_load = 1; t_last = 1; t_data = 32'h400 + 32'(4 * i);
      m_load = 1; m_data = 32'h500 + 32'(4 * i);
      step();
    end
    t_load = 0; m_load = 0; t_last = 0;
    for (int i = 0; i < 12; i++) step();
    check("tie_count", obs.size(), 4);
    ti = 0; mi = 0;
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      check($sformatf("tie_who%0d", i), obs[i][39], exp_m[i]);
      if (obs[i][39]) begin
        check($sformatf("tie_data%0d", i), obs[i][31:0], 32'h500 + 32'(4 * mi));
        mi++;
      end else begin
        check($sformatf("tie_data%0d", i), obs[i][31:0], 32'h400 + 32'(4 * ti));
        ti++;
      end
    end

    // ---------------- reset mid-burst ----------------
    do_reset();
    t_type = 3'b111; t_cbe = 4'h9;
    for (int i = 0; i < 4; i++) begin
      t_load = 1; t_data = 32'h600 + 32'(4 * i); t_last = (i == 3);
      step();
    end
    t_load = 0; t_last = 0;
    check("mid_burst_active", o_load, 1);
    #3;
    rst = 1;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post_release_load%0d", i), o_load, 0);
    end

    // ---------------- randomized traffic vs. transaction-level model ----------------
    do_reset();
    obs.delete(); tq.delete(); mq.delete();
    tgt_left = 0;
    for (int c = 0; c < 2600; c++) begin
      t_load = 0; m_load = 0;
      if (c < 2500 && tgt_left == 0 && $urandom_range(0, 3) == 0) tgt_left = $urandom_range(1, 5);
      if (tgt_left != 0 && t_room && $urandom_range(0, 3) != 0) begin
        t_type = 3'($urandom); t_cbe = 4'($urandom); t_data = $urandom;
        t_last = (tgt_left == 1);
        t_load = 1;
        tq.push_back({t_last, t_type, t_cbe, t_data});
        tgt_left--;
      end
      if (c < 2500 && m_room && $urandom_range(0, 4) == 0) begin
        m_type = 3'($urandom); m_cbe = 4'($urandom); m_data = $urandom;
        m_load = 1;
        mq.push_back({m_type, m_cbe, m_data});
      end
      if (c < 2500) begin
        if ($urandom_range(0, 7) == 0) meta = ~meta;
      end else begin
        meta = 1;
      end
      step();
    end
    t_load = 0; m_load = 0; t_last = 0;
    check("rnd_ref_closed", tgt_left, 0);
    total = tq.size() + mq.size();
    bound = 0;
    while (obs.size() < total && bound < 400) begin step(); bound++; end
    step();
    check("rnd_total", obs.size(), total);
    in_tgt = 0;
    foreach (obs[i]) begin
      e = obs[i];
      check("rnd_atomic", in_tgt && e[39], 0);
      if (e[39]) begin
        if (mq.size() == 0) check("rnd_mst_extra", 1, 0);
        else begin
          me = mq.pop_front();
          check("rnd_mst_entry", e, {1'b1, me});
        end
      end else begin
        if (tq.size() == 0) check("rnd_tgt_extra", 1, 0);
        else begin
          te = tq.pop_front();
          check("rnd_tgt_entry", e, {1'b0, te[38:0]});
          in_tgt = !te[39];
        end
      end
    end
    check("rnd_terr", t_err, 0);
    check("rnd_merr", m_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
